// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: one START/addr/ack/byte/ack/STOP transfer per request.
// SCL and SDA are open-drain enables; SCL comes from a quarter-period divider.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [6:0] req_addr,
  input  logic       req_rw,
  input  logic [7:0] req_wdata,
  input  logic       sda_in,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, MACK, STOP
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [1:0]    qtr, qtr_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    addr_byte, wdata_q, rx_shift;
  logic          rw_q;
  logic          scl_n, sda_n;

  logic tick_q, samp, slot_end;
  assign tick_q   = (div_cnt == DW'(CLK_DIV - 1));
  assign samp     = tick_q && (qtr == 2'd2);
  assign slot_end = tick_q && (qtr == 2'd3);

  // Next-state and counters; outputs are derived from the next state so the
  // registered pad enables line up exactly with the quarter they belong to.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    qtr_n   = qtr;
    bit_n   = bit_cnt;
    if (state == IDLE) begin
      div_n = '0;
      qtr_n = 2'd0;
      if (req) state_n = START;
    end else begin
      div_n = tick_q ? '0 : div_cnt + 1'b1;
      qtr_n = tick_q ? qtr + 2'd1 : qtr;
      if (slot_end) begin
        case (state)
          START: begin state_n = ADDR; bit_n = 3'd7; end
          ADDR:  if (bit_cnt == 3'd0) state_n = AACK; else bit_n = bit_cnt - 3'd1;
          AACK:  if (nack) state_n = STOP;
                 else begin state_n = rw_q ? RDATA : WDATA; bit_n = 3'd7; end
          WDATA: if (bit_cnt == 3'd0) state_n = WACK; else bit_n = bit_cnt - 3'd1;
          WACK:  state_n = STOP;
          RDATA: if (bit_cnt == 3'd0) state_n = MACK; else bit_n = bit_cnt - 3'd1;
          MACK:  state_n = STOP;
          STOP:  state_n = IDLE;
          default: state_n = IDLE;
        endcase
      end
    end

    scl_n = 1'b0;
    sda_n = 1'b0;
    case (state_n)
      START: sda_n = qtr_n[1];
      ADDR:  begin scl_n = ~qtr_n[1]; sda_n = ~addr_byte[bit_n]; end
      WDATA: begin scl_n = ~qtr_n[1]; sda_n = ~wdata_q[bit_n]; end
      AACK, WACK, RDATA, MACK: scl_n = ~qtr_n[1];
      STOP:  begin scl_n = ~qtr_n[1]; sda_n = (qtr_n != 2'd3); end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      qtr       <= 2'd0;
      bit_cnt   <= 3'd0;
      addr_byte <= 8'h00;
      wdata_q   <= 8'h00;
      rw_q      <= 1'b0;
      rx_shift  <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      rdata     <= 8'h00;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      qtr     <= qtr_n;
      bit_cnt <= bit_n;
      scl_oe  <= scl_n;
      sda_oe  <= sda_n;
      done    <= (state == STOP) && slot_end;

      if (state == IDLE && req) begin
        addr_byte <= {req_addr, req_rw};
        wdata_q   <= req_wdata;
        rw_q      <= req_rw;
        nack      <= 1'b0;
        busy      <= 1'b1;
      end else if (state == STOP && slot_end) begin
        busy <= 1'b0;
      end

      if (samp) begin
        case (state)
          AACK, WACK: if (sda_in) nack <= 1'b1;
          RDATA:      rx_shift <= {rx_shift[6:0], sda_in};
          default: ;
        endcase
      end

      // Read data is published only once the byte has been fully clocked in.
      if (state == MACK && slot_end) rdata <= rx_shift;
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl: DUT at CLK_DIV=4 against a behavioural
// slave at 7'h01, plus a CLK_DIV=2 instance with a directly driven sda_in.
module tb_i2c_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
  endtask

  // DUT at CLK_DIV=4
  logic       req, req_rw, sda_in, busy, done, nack, scl_oe, sda_oe;
  logic [6:0] req_addr;
  logic [7:0] req_wdata, rdata;

  i2c_master_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .sda_in(sda_in), .busy(busy), .done(done), .nack(nack),
    .rdata(rdata), .scl_oe(scl_oe), .sda_oe(sda_oe));

  // DUT at CLK_DIV=2, no bus model
  logic       req2, req_rw2, sda_in2, busy2, done2, nack2, scl_oe2, sda_oe2;
  logic [6:0] req_addr2;
  logic [7:0] req_wdata2, rdata2;
  int unsigned pulse_at = 32'hFFFF_FFFF;
  assign sda_in2 = (cyc != pulse_at);

  i2c_master_ctrl #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_addr(req_addr2), .req_rw(req_rw2),
    .req_wdata(req_wdata2), .sda_in(sda_in2), .busy(busy2), .done(done2), .nack(nack2),
    .rdata(rdata2), .scl_oe(scl_oe2), .sda_oe(sda_oe2));

  // Open-drain bus and slave model at 7'h01 (read byte 0xCC)
  logic s_oe = 1'b0;
  logic scl, sda, scl_r, sda_r;
  assign scl    = ~scl_oe;
  assign sda    = ~(sda_oe | s_oe);
  assign sda_in = sda;

  typedef enum {S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_MACK} sst_t;
  sst_t       st = S_IDLE;
  logic [7:0] sh = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic       s_rw = 1'b0;
  logic       mack_seen = 1'b0;
  int         cnt = 0;
  int unsigned n_stop = 0;

  always @(posedge clk) begin
    scl_r <= scl;
    sda_r <= sda;
    if (!rst_n) begin
      st <= S_IDLE; s_oe <= 1'b0;
    end else if (scl && scl_r && sda_r && !sda) begin
      st <= S_ADDR; cnt <= 0; s_oe <= 1'b0; mack_seen <= 1'b0;
    end else if (scl && scl_r && !sda_r && sda) begin
      st <= S_IDLE; s_oe <= 1'b0; n_stop <= n_stop + 1;
    end else begin
      case (st)
        S_ADDR, S_WR: begin
          if (scl && !scl_r) begin sh <= {sh[6:0], sda}; cnt <= cnt + 1; end
          if (!scl && scl_r && cnt == 8) begin
            if (st == S_WR) begin
              data_in <= sh; s_oe <= 1'b1; st <= S_WACK;
            end else if (sh[7:1] == 7'h01) begin
              s_rw <= sh[0]; s_oe <= 1'b1; st <= S_AACK;
            end else st <= S_IDLE;
          end
        end
        S_AACK: if (!scl && scl_r) begin
          cnt <= 0;
          if (s_rw) begin st <= S_RD; sh <= 8'hCC; s_oe <= ~1'b1; end
          else begin st <= S_WR; s_oe <= 1'b0; end
        end
        S_WACK: if (!scl && scl_r) begin s_oe <= 1'b0; st <= S_IDLE; end
        S_RD: begin
          if (scl && !scl_r) cnt <= cnt + 1;
          if (!scl && scl_r) begin
            if (cnt == 8) begin s_oe <= 1'b0; st <= S_MACK; end
            else begin s_oe <= ~sh[6]; sh <= {sh[6:0], 1'b0}; end
          end
        end
        S_MACK: begin
          if (scl && !scl_r) mack_seen <= sda;
          if (!scl && scl_r) st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  // Scoreboard
  typedef struct {
    int unsigned done_cyc;
    logic        nack;
    logic [7:0]  rdata;
    logic        chk_wr;
    logic [7:0]  wdata;
    logic        chk_mack;
    int unsigned stops;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int unsigned exp_stops = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL dut_unexpected_done: got done=1 expected none (cyc %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("nack", {31'd0, nack}, {31'd0, e.nack});
        chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
        if (e.chk_wr) chk("slave_data_in", {24'd0, data_in}, {24'd0, e.wdata});
        if (e.chk_mack) chk("mack_released", {31'd0, mack_seen}, 32'd1);
        chk("stop_count", n_stop, e.stops);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        n_chk++;
        $display("FAIL dut2_unexpected_done: got done=1 expected none (cyc %0d)", cyc);
      end else begin
        e = q2.pop_front();
        chk("dut2_done_cycle", cyc, e.done_cyc);
        chk("dut2_nack", {31'd0, nack2}, {31'd0, e.nack});
        chk("dut2_rdata", {24'd0, rdata2}, {24'd0, e.rdata});
      end
    end
  end

  task automatic push1(input int unsigned dc, input logic en, input logic [7:0] er,
                       input logic cw, input logic [7:0] ew, input logic cm);
    exp_t e;
    exp_stops++;
    e.done_cyc = dc; e.nack = en; e.rdata = er; e.chk_wr = cw; e.wdata = ew;
    e.chk_mack = cm; e.stops = exp_stops;
    q1.push_back(e);
  endtask

  task automatic issue(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                       output int unsigned acc);
    @(negedge clk);
    req_addr = a; req_rw = rw; req_wdata = wd; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    acc = cyc;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic issue2(input int unsigned off, input int unsigned lat, input logic en,
                        input logic [7:0] er, output int unsigned acc);
    exp_t e;
    @(negedge clk);
    req_addr2 = 7'h22; req_rw2 = 1'b1; req_wdata2 = 8'h00; req2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req2 = 1'b0;
    acc = cyc;
    pulse_at = acc + off;
    e.done_cyc = acc + lat; e.nack = en; e.rdata = er; e.chk_wr = 1'b0;
    e.wdata = 8'h00; e.chk_mack = 1'b0; e.stops = 0;
    q2.push_back(e);
  endtask

  task automatic drain(input bit second);
    int k = 0;
    while (k < 2000 && (second ? (q2.size() != 0 || busy2) : (q1.size() != 0 || busy))) begin
      @(negedge clk);
      k++;
    end
    if (second ? (q2.size() != 0) : (q1.size() != 0)) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending expected 0", second ? q2.size() : q1.size());
    end
    pulse_at = 32'hFFFF_FFFF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned acc;
    logic [7:0] pat;
    int k;
    rst_n = 1'b0; req = 1'b0; req_addr = '0; req_rw = 1'b0; req_wdata = '0;
    req2 = 1'b0; req_addr2 = '0; req_rw2 = 1'b0; req_wdata2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_nack", {31'd0, nack}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    rst_n = 1'b1;

    // write 0xA5 to 7'h01
    issue(7'h01, 1'b0, 8'hA5, acc);
    push1(acc + 320, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0);
    drain(1'b0);

    // read from 7'h01
    issue(7'h01, 1'b1, 8'h00, acc);
    push1(acc + 320, 1'b0, 8'hCC, 1'b0, 8'h00, 1'b1);
    drain(1'b0);

    // address NACK: no data clocked, slave byte and rdata unchanged
    issue(7'h22, 1'b0, 8'h77, acc);
    push1(acc + 176, 1'b1, 8'hCC, 1'b1, 8'hA5, 1'b0);
    drain(1'b0);

    // back-to-back with req held and inputs disturbed while busy
    @(negedge clk);
    req_addr = 7'h01; req_rw = 1'b0; req_wdata = 8'h3C; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    push1(acc + 320, 1'b0, 8'hCC, 1'b1, 8'h3C, 1'b0);
    push1(acc + 641, 1'b0, 8'hCC, 1'b1, 8'h5A, 1'b0);
    req_addr = 7'h22; req_wdata = 8'h5A;
    repeat (100) @(negedge clk);
    req_addr = 7'h01;
    k = 0;
    while (!done && k < 1000) begin @(negedge clk); k++; end
    @(negedge clk);
    req = 1'b0;
    chk("b2b_second_accepted", {31'd0, busy}, 32'd1);
    drain(1'b0);

    // reset during the STOP of an address-NACK transfer
    issue(7'h22, 1'b0, 8'h11, acc);
    while (cyc < acc + 165) @(negedge clk);
    chk("pre_reset_nack", {31'd0, nack}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_nack", {31'd0, nack}, 32'd0);
    chk("midrst_rdata", {24'd0, rdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    // CLK_DIV=2: ack low one cycle early -> NACK, also check SCL shape
    issue2(76, 88, 1'b1, 8'h00, acc);
    while (cyc < acc + 8) @(negedge clk);
    pat = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[6:0], scl_oe2};
      @(negedge clk);
    end
    chk("dut2_scl_slot", {24'd0, pat}, 32'h000000F0);
    drain(1'b1);
    // ack low exactly on the last cycle of q2 -> ACK, read completes with 0xFF
    issue2(77, 160, 1'b0, 8'hFF, acc);
    drain(1'b1);
    // ack low one cycle late -> NACK, rdata holds
    issue2(78, 88, 1'b1, 8'hFF, acc);
    drain(1'b1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Single-master I2C transaction controller that sequences one complete one-byte bus transfer per request: START, 7-bit address + R/W, address ACK, one data byte, data ACK/NACK, STOP. It sits between the system-side request logic and the open-drain SCL/SDA pads, and drives the bus that our `i2c_slave` devices (7-bit address, MSB-first bytes) sit on. SCL is generated from the system clock by a programmable divider; the bus is driven only as open-drain enables.

## Interface
- `CLK_DIV`, 250: system clocks per SCL quarter-period; legal ≥ 2. SCL period = 4·CLK_DIV.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req` in 1: transaction request; sampled only while `busy`=0.
- `req_addr` in 7: target slave address.
- `req_rw` in 1: 0 = write (master → slave), 1 = read (slave → master).
- `req_wdata` in 8: byte to write; ignored for reads.
- `sda_in` in 1: synchronised SDA pad level.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse at transaction end.
- `nack` out 1: 1 = an ACK slot sampled high in the last transaction.
- `rdata` out 8: byte received by the last successful read.
- `scl_oe` out 1: 1 = pull SCL low; 0 = release.
- `sda_oe` out 1: 1 = pull SDA low; 0 = release.

## Operation
- **Reset values:** `scl_oe`=0, `sda_oe`=0, `busy`=0, `done`=0, `nack`=0, `rdata`=8'h00. State is IDLE and the counters are cleared.
- **Acceptance:** in IDLE with `req`=1, the block captures `req_addr`, `req_rw` and `req_wdata`, clears `nack`, and sets `busy` the next cycle. `req` is ignored while `busy`=1.
- **Shift register:** the address byte is {`req_addr`, `req_rw`}. All bytes go out MSB first.
- **States:** IDLE → START → ADDR (8 bits) → AACK. Then:
  - WDATA (8 bits) → WACK → STOP, for writes.
  - RDATA (8 bits) → MACK → STOP, for reads.
  - STOP → IDLE.
- **Bit time:** each bit slot is 4 quarters, q0–q3, each CLK_DIV clocks long.
  - q0–q1: SCL low. SDA is updated on the first cycle of q0.
  - q2–q3: SCL released.
  - Sampling takes `sda_in` on the last cycle of q2.
- **START:** q0–q1 both lines released; q2–q3 SCL released, SDA low.
- **ADDR/WDATA:** `sda_oe` = ~bit.
- **AACK/WACK/RDATA:** SDA released.
  - AACK: a sampled 1 sets `nack` and goes straight to STOP, skipping the data phase.
  - WACK: a sampled 1 sets `nack`, then STOP.
  - RDATA: samples shift into `rdata` MSB first. `rdata` is updated only when the read completes through MACK.
- **MACK:** the master sends NACK (SDA released) to terminate the single-byte read.
- **STOP:** q0–q1 SCL low, SDA low; q2 SCL released, SDA low; q3 SCL released, SDA released.
- **End of transaction:** after the STOP q3 ends, `done`=1 for one cycle, `busy`=0 in that same cycle, and the state returns to IDLE. A new `req` may be accepted in the `done` cycle.
- **Output hold:** `nack` and `rdata` hold until the next acceptance. `rdata` is unchanged by writes and by NACKed reads.
- **Reset mid-transfer:** the block releases both lines on the reset edge and returns to IDLE. No STOP is generated.
- **No clock stretching or arbitration:** SCL is not monitored; this block is the only master.

## Timing
- Request sampled at edge T; START q0 begins at T+1.
- Full transaction: 20 bit slots (START + 9 + 9 + STOP) = 80·CLK_DIV clocks. `done` is high at cycle T+1+80·CLK_DIV.
- Address NACK: 11 slots = 44·CLK_DIV clocks. `done` is high at T+1+44·CLK_DIV.
- `busy` is high from T+1 through the cycle before `done`.
- SDA changes only while SCL is low, except in START and STOP.
- The divider counter runs 0..CLK_DIV−1 and wraps into the next quarter. The quarter counter wraps q3→q0 together with the bit-counter step.
- The bit counter counts 7→0 and moves to the ACK state after bit 0.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles mid-transaction → `scl_oe`=`sda_oe`=0, `busy`=0, `nack`=0, `rdata`=00 on the next edge.
- **Write:** CLK_DIV=4, `i2c_slave` model at 7'h01. Request write 0xA5 to 7'h01 → `done` at T+321, `nack`=0, slave `data_in`=0xA5, bus shows START/STOP.
- **Read:** request read from 7'h01 → `done` at T+321, `rdata`=0xCC, `nack`=0, SDA released during MACK.
- **Address NACK:** request write to 7'h22 (no device) → `nack`=1, `done` at T+177, no data bits clocked, `rdata` unchanged.
- **Busy and back-to-back:** hold `req`=1 continuously → the second transaction is accepted in the `done` cycle, and `req` changes while `busy`=1 have no effect on the captured address/data.
- **Divider:** CLK_DIV=2 → SCL high and low each 4 clocks, and sampling lands on the last cycle of q2.
